// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic sample generator.
// Optional build macro used by the top: POLY_SAT_MIX_EN.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    localparam int DEF_PHASE_W  = 24;
    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_VOICES   = 4;
    localparam int DEF_LUT_BITS = 10;

    // Phase steps of MIDI notes 120..131 for a 24-bit accumulator at 48 kHz;
    // lower octaves are derived by right-shifting.
    function automatic logic [23:0] top_octave_step(input logic [3:0] semi);
        case (semi)
            4'd0:    return 24'd2926232;
            4'd1:    return 24'd3100235;
            4'd2:    return 24'd3284585;
            4'd3:    return 24'd3479896;
            4'd4:    return 24'd3686822;
            4'd5:    return 24'd3906052;
            4'd6:    return 24'd4138318;
            4'd7:    return 24'd4384395;
            4'd8:    return 24'd4645104;
            4'd9:    return 24'd4921317;
            4'd10:   return 24'd5213953;
            4'd11:   return 24'd5523991;
            default: return 24'd0;
        endcase
    endfunction

endpackage

// File: rtl/poly_sample_generator_tables.sv
// Frequency-step and sine lookup blocks used by the polyphonic generator.
module tableFrequencyStep
    import synth_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic [6:0]         index,
    output logic [PHASE_W-1:0] step
);
    logic [3:0]          octave;
    logic [3:0]          semi;
    logic [PHASE_W+23:0] scaled;

    // Rescale the 24-bit reference step to PHASE_W, then drop one bit per octave below the top.
    always_comb begin
        octave = 4'(index / 7'd12);
        semi   = 4'(index % 7'd12);
        scaled = {{PHASE_W{1'b0}}, top_octave_step(semi)} << PHASE_W;
        scaled = scaled >> (6'd34 - {2'b00, octave});
        step   = scaled[PHASE_W-1:0];
    end
endmodule

module tableSinewave #(
    parameter int LUT_BITS = 10,
    parameter int SAMPLE_W = 12
) (
    input  logic [LUT_BITS-1:0]        addr,
    output logic signed [SAMPLE_W-1:0] sample
);
    localparam int QW = LUT_BITS - 2;
    localparam int PW = 2 * LUT_BITS + SAMPLE_W;
    localparam logic [PW-1:0] AMP  = PW'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic [PW-1:0] SPAN = PW'(2 ** (QW + 1));

    logic [QW-1:0]       x;
    logic [SAMPLE_W-1:0] mag;

    // Quarter-wave parabola x(2N-x)/N^2, mirrored and negated per quadrant; zero at address 0.
    always_comb begin
        x      = addr[LUT_BITS-2] ? ~addr[QW-1:0] : addr[QW-1:0];
        mag    = SAMPLE_W'((PW'(x) * (SPAN - PW'(x)) * AMP) >> (2 * QW));
        sample = addr[LUT_BITS-1] ? -$signed(mag) : $signed(mag);
    end
endmodule

// File: rtl/poly_sample_generator_wave_shaper.sv
// Combinational waveform shaper: phase + mode -> signed sample.
module wave_shaper
    import synth_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LUT_BITS = DEF_LUT_BITS
) (
    input  logic [PHASE_W-1:0]         phase,
    input  wave_mode_t                 mode,
    output logic signed [SAMPLE_W-1:0] sample
);
    localparam logic signed [SAMPLE_W-1:0] POS_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic signed [SAMPLE_W-1:0] sine_s;
    logic [SAMPLE_W-1:0]        top;
    logic [SAMPLE_W-1:0]        tri_raw;
    logic                       unused_phase_lsbs;

    assign unused_phase_lsbs = ^phase[PHASE_W-SAMPLE_W-1:0];

    tableSinewave #(
        .LUT_BITS(LUT_BITS),
        .SAMPLE_W(SAMPLE_W)
    ) u_sine (
        .addr  (phase[PHASE_W-1 -: LUT_BITS]),
        .sample(sine_s)
    );

    always_comb begin
        top     = phase[PHASE_W-1 -: SAMPLE_W];
        tri_raw = phase[PHASE_W-1] ? ~(top << 1) : (top << 1);
        case (mode)
            WAVE_SINE:   sample = sine_s;
            WAVE_SQUARE: sample = phase[PHASE_W-1] ? -POS_MAX : POS_MAX;
            WAVE_SAW:    sample = {~top[SAMPLE_W-1], top[SAMPLE_W-2:0]};
            default:     sample = {~tri_raw[SAMPLE_W-1], tri_raw[SAMPLE_W-2:0]};
        endcase
    end
endmodule

// File: rtl/poly_sample_generator.sv
// Time-multiplexed polyphonic oscillator bank with one mixed output per sample tick.
// Build option POLY_SAT_MIX_EN: saturated sum mixing instead of averaging.
module poly_sample_generator
    import synth_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int VOICES   = DEF_VOICES,
    parameter int LUT_BITS = DEF_LUT_BITS
) (
    input  logic                        inCLK,
    input  logic                        inRST,
    input  logic                        inSampleTick,
    input  logic                        inNoteValid,
    output logic                        outNoteReady,
    input  logic [$clog2(VOICES)-1:0]   inNoteVoice,
    input  logic                        inNoteOn,
    input  logic [6:0]                  inMidiFrequencyIndex,
    input  logic [1:0]                  inWaveMode,
    output logic signed [SAMPLE_W-1:0]  outSample,
    output logic                        outSampleValid,
    output logic                        outOverrun
);
    localparam int VW    = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + VW;

    state_t                     state;
    logic [VW-1:0]              v;
    logic [PHASE_W-1:0]         phase [VOICES];
    logic [6:0]                 index [VOICES];
    wave_mode_t                 mode  [VOICES];
    logic [VOICES-1:0]          gate;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    voice_term;
    logic signed [SAMPLE_W-1:0] shaped;
    logic [PHASE_W-1:0]         step;
    logic                       note_fire;

`ifdef POLY_SAT_MIX_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

    function automatic logic signed [SAMPLE_W-1:0] mix_sat(input logic signed [ACC_W-1:0] sum);
        if (sum > SAT_HI)      return SAMPLE_W'(SAT_HI);
        else if (sum < SAT_LO) return SAMPLE_W'(SAT_LO);
        else                   return SAMPLE_W'(sum);
    endfunction
`else
    function automatic logic signed [SAMPLE_W-1:0] mix_avg(input logic signed [ACC_W-1:0] sum);
        return SAMPLE_W'(sum >>> VW);
    endfunction
`endif

    assign outNoteReady = (state == ST_IDLE) && !inRST;
    assign note_fire    = inNoteValid && outNoteReady;

    tableFrequencyStep #(.PHASE_W(PHASE_W)) u_step (
        .index(index[v]),
        .step (step)
    );

    wave_shaper #(
        .PHASE_W (PHASE_W),
        .SAMPLE_W(SAMPLE_W),
        .LUT_BITS(LUT_BITS)
    ) u_shaper (
        .phase (phase[v]),
        .mode  (mode[v]),
        .sample(shaped)
    );

    always_comb begin
        voice_term = gate[v] ? {{VW{shaped[SAMPLE_W-1]}}, shaped} : '0;
        acc_next   = acc + voice_term;
    end

    always_ff @(posedge inCLK) begin
        if (inRST) begin
            state          <= ST_IDLE;
            v              <= '0;
            acc            <= '0;
            gate           <= '0;
            outSample      <= '0;
            outSampleValid <= 1'b0;
            outOverrun     <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
                index[i] <= '0;
                mode[i]  <= WAVE_SINE;
            end
        end else begin
            outSampleValid <= 1'b0;
            if (inSampleTick && state != ST_IDLE)
                outOverrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (note_fire) begin
                        if (inNoteOn) begin
                            gate[inNoteVoice]  <= 1'b1;
                            index[inNoteVoice] <= inMidiFrequencyIndex;
                            mode[inNoteVoice]  <= wave_mode_t'(inWaveMode);
                            phase[inNoteVoice] <= '0;
                        end else begin
                            gate[inNoteVoice]  <= 1'b0;
                        end
                    end
                    if (inSampleTick) begin
                        state <= ST_SWEEP;
                        v     <= '0;
                        acc   <= '0;
                    end
                end
                // Sweep: one voice per cycle; the final voice's sum lands on the output
                // so the sample is visible during EMIT.
                ST_SWEEP: begin
                    if (gate[v])
                        phase[v] <= phase[v] + step;
                    acc <= acc_next;
                    if (v == VW'(VOICES - 1)) begin
                        state          <= ST_EMIT;
                        outSampleValid <= 1'b1;
`ifdef POLY_SAT_MIX_EN
                        outSample      <= mix_sat(acc_next);
`else
                        outSample      <= mix_avg(acc_next);
`endif
                    end else begin
                        v <= v + 1'b1;
                    end
                end
                ST_EMIT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_sample_generator.sv
// Scoreboard bench for poly_sample_generator (VOICES=4, SAMPLE_W=12, PHASE_W=24).
module tb_poly_sample_generator;
    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              nvalid;
    logic              nready;
    logic [1:0]        nvoice;
    logic              non;
    logic [6:0]        nidx;
    logic [1:0]        nmode;
    logic signed [11:0] sample;
    logic              svalid;
    logic              overrun;

    int tests = 0;
    int fails = 0;
    logic signed [11:0] exp_q[$];

    int unsigned m_phase[4];
    bit          m_gate[4];
    int          m_idx[4];
    int          m_mode[4];

    always #5 clk = ~clk;

    poly_sample_generator dut (
        .inCLK               (clk),
        .inRST               (rst),
        .inSampleTick        (tick),
        .inNoteValid         (nvalid),
        .outNoteReady        (nready),
        .inNoteVoice         (nvoice),
        .inNoteOn            (non),
        .inMidiFrequencyIndex(nidx),
        .inWaveMode          (nmode),
        .outSample           (sample),
        .outSampleValid      (svalid),
        .outOverrun          (overrun)
    );

    // Scoreboard: every valid pulse pops one expected sample.
    always @(negedge clk) begin
        if (svalid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample got %0d required no pulse", sample);
            end else begin
                logic signed [11:0] e;
                e = exp_q.pop_front();
                if (sample !== e) begin
                    fails++;
                    $display("FAIL sample got %0d required %0d", sample, e);
                end
            end
        end
    end

    function automatic int model_step(int idx);
        real f;
        f = 440.0 * (2.0 ** ((idx - 69) / 12.0));
        return int'(f * 16777216.0 / 48000.0);
    endfunction

    function automatic int shape(int unsigned p, int md);
        int top, r;
        top = int'((p >> 12) & 32'hFFF);
        case (md)
            0: return (p == 0) ? 0 : $rtoi(2047.0 * $sin(6.283185307 * p / 16777216.0));
            1: return p[23] ? -2047 : 2047;
            2: return top - 2048;
            default: begin
                r = (top << 1) & 32'hFFF;
                if (p[23]) r = (~r) & 32'hFFF;
                return r - 2048;
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0; m_gate[i] = 0; m_idx[i] = 0; m_mode[i] = 0;
        end
    endtask

    task automatic model_tick();
        int s, e;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_gate[i]) begin
                s += shape(m_phase[i], m_mode[i]);
                m_phase[i] = (m_phase[i] + model_step(m_idx[i])) & 32'hFFFFFF;
            end
        end
`ifdef POLY_SAT_MIX_EN
        e = (s > 2047) ? 2047 : (s < -2047) ? -2047 : s;
`else
        e = s >>> 2;
`endif
        exp_q.push_back(12'(e));
    endtask

    task automatic model_note(int vc, bit on, int idx, int md);
        if (on) begin
            m_gate[vc] = 1; m_idx[vc] = idx; m_mode[vc] = md; m_phase[vc] = 0;
        end else begin
            m_gate[vc] = 0;
        end
    endtask

    task automatic note(int vc, bit on, int idx, int md);
        nvalid = 1; nvoice = 2'(vc); non = on; nidx = 7'(idx); nmode = 2'(md);
        model_note(vc, on, idx, md);
        step();
        nvalid = 0;
    endtask

    task automatic do_tick();
        model_tick();
        tick = 1;
        step();
        tick = 0;
        repeat (7) step();
    endtask

    task automatic reset_dut();
        rst = 1;
        step(); step();
        rst = 0;
        model_clear();
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        tests++;
        if (nready !== 1'b0) begin fails++; $display("FAIL ready_in_reset got %b required 0", nready); end
        step();
        tests++;
        if (sample !== 12'sd0) begin fails++; $display("FAIL reset_sample got %0d required 0", sample); end
        tests++;
        if (svalid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b required 0", svalid); end
        tests++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b required 0", overrun); end
        rst = 0;
        model_clear();
        #1;
        tests++;
        if (nready !== 1'b1) begin fails++; $display("FAIL ready_idle got %b required 1", nready); end
        step();
    endtask

    task automatic test_silence_latency();
        int got;
        got = -1;
        model_tick();
        tick = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            tick = 0;
            if (svalid && got < 0) got = i;
        end
        tests++;
        if (got != 5) begin fails++; $display("FAIL latency got %0d required 5", got); end
    endtask

    task automatic test_square_single();
        note(0, 1, 69, 1);
        do_tick();
        do_tick();
    endtask

    task automatic test_square_pair();
        reset_dut();
        note(0, 1, 69, 1);
        note(1, 1, 69, 1);
        do_tick();
    endtask

    task automatic test_square_wrap();
        reset_dut();
        note(2, 1, 127, 1);
        for (int i = 0; i < 5; i++) do_tick();
    endtask

    task automatic test_saw_tri_note_off();
        reset_dut();
        note(0, 1, 69, 2);
        note(1, 1, 60, 0);
        note(3, 1, 69, 3);
        do_tick();
        note(1, 0, 0, 0);
        do_tick();
        note(0, 0, 0, 0);
        note(3, 0, 0, 0);
        do_tick();
        note(0, 1, 69, 2);
        do_tick();
    endtask

    task automatic test_overrun();
        int pulses;
        reset_dut();
        model_tick();
        tick = 1;
        step();
        nvalid = 1; nvoice = 2'd0; non = 1; nidx = 7'd69; nmode = 2'd1;
        #1;
        tests++;
        if (nready !== 1'b0) begin fails++; $display("FAIL ready_in_sweep got %b required 0", nready); end
        step();
        tick = 0; nvalid = 0;
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b required 1", overrun); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (svalid) pulses++;
            step();
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL single_pulse got %0d required 1", pulses); end
        do_tick();
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b required 1", overrun); end
    endtask

    task automatic test_tick_with_note();
        reset_dut();
        nvalid = 1; nvoice = 2'd1; non = 1; nidx = 7'd69; nmode = 2'd1;
        model_note(1, 1, 69, 1);
        model_tick();
        tick = 1;
        step();
        tick = 0; nvalid = 0;
        repeat (7) step();
    endtask

    task automatic test_reset_mid_sweep();
        int pulses;
        reset_dut();
        note(0, 1, 69, 1);
        tick = 1;
        step();
        tick = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        model_clear();
        #1;
        tests++;
        if (nready !== 1'b1) begin fails++; $display("FAIL idle_after_reset got %b required 1", nready); end
        tests++;
        if (sample !== 12'sd0 || overrun !== 1'b0) begin
            fails++; $display("FAIL outputs_after_reset got %0d/%b required 0/0", sample, overrun);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (svalid) pulses++;
            step();
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL aborted_sweep_pulses got %0d required 0", pulses); end
        do_tick();
    endtask

    initial begin
        rst = 1; tick = 0; nvalid = 0; nvoice = 0; non = 0; nidx = 0; nmode = 0;
        model_clear();
        step();
        test_reset();
        test_silence_latency();
        test_square_single();
        test_square_pair();
        test_square_wrap();
        test_saw_tri_note_off();
        test_overrun();
        test_tick_with_note();
        test_reset_mid_sweep();
        repeat (4) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL missing_samples got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/poly_sample_generator.md
Name: poly_sample_generator

Overview:
Polyphonic successor to the single-voice phase-accumulator sample generator. It runs VOICES independent oscillators, time-multiplexed over one datapath, each with its own MIDI frequency index, wave mode and gate. On every sample-rate tick it steps every active voice, shapes its waveform, mixes the voices and presents one signed mixed sample. It sits between the MIDI note decoder and the DAC/sample serializer.

Parameters:
PHASE_W, 24, phase accumulator width per voice
SAMPLE_W, 12, signed output sample width
VOICES, 4, voice count; power of two, 2..16
LUT_BITS, 10, phase MSBs used to address the sine table

Ports:
inCLK  input  1  system clock
inRST  input  1  reset; synchronous, active-high
inSampleTick  input  1  one-cycle sample-rate strobe
inNoteValid  input  1  note command valid
outNoteReady  output  1  note command accepted when high together with inNoteValid
inNoteVoice  input  log2(VOICES)  target voice of the command
inNoteOn  input  1  1 = note on (gate), 0 = note off
inMidiFrequencyIndex  input  7  MIDI note index for the note-on
inWaveMode  input  2  0 sine, 1 square, 2 saw, 3 triangle
outSample  output  SAMPLE_W  signed mixed sample
outSampleValid  output  1  one-cycle pulse when outSample updates
outOverrun  output  1  sticky; a tick arrived while the mixer was busy

Behaviour:
- One clock (inCLK). Reset is synchronous and active-high (inRST). It clears all voice phases, gates, indices and modes to 0; FSM to IDLE; outSample=0, outSampleValid=0, outOverrun=0. Reset mid-sweep aborts the sweep and emits no sample.
- FSM: IDLE -> SWEEP (exactly VOICES cycles, voice counter v = 0..VOICES-1) -> EMIT (1 cycle) -> IDLE.
- IDLE with inSampleTick=1 moves to SWEEP with v=0 and accumulator cleared. Latency: tick at cycle T gives outSample and outSampleValid=1 at T+VOICES+1.
- inSampleTick outside IDLE is ignored and sets outOverrun=1. outOverrun clears only on reset.
- SWEEP, voice v:
  - Active voice: phase[v] += freqStep(index[v]), wrapping mod 2^PHASE_W. Its shaped sample is added to the accumulator (SAMPLE_W + log2(VOICES) bits, signed).
  - Inactive voice: phase is held and it contributes 0.
  - The shaped sample uses the pre-increment phase.
- Wave shaping from p = phase[v] (pre-increment):
  - Sine: tableSinewave(p[PHASE_W-1 -: LUT_BITS]).
  - Square: p MSB=0 gives +max (0x7FF at 12 bits); MSB=1 gives -max (0x801 at 12 bits).
  - Saw: top SAMPLE_W bits of p with the MSB inverted (offset binary to two's complement).
  - Triangle: t = top SAMPLE_W bits of p, then t <<1 and bitwise inverted when p MSB=1. Apply the saw MSB inversion to the result.
- EMIT: outSample = accumulator >>> log2(VOICES) (arithmetic; averaging, never overflows). outSampleValid=1 for this cycle only.
- Note handshake: outNoteReady = (state==IDLE) && !inRST. A transfer occurs when inNoteValid && outNoteReady.
  - Note-on: gate=1, index and mode latched, phase reset to 0.
  - Note-off: gate=0, phase held, index and mode unchanged.
- Tick and note in the same IDLE cycle: the note is applied first. The sweep uses the updated voice state starting the next cycle.

Optional Feature:
POLY_SAT_MIX_EN:
- Defined: EMIT outputs the raw accumulator sum saturated to [-(2^(SAMPLE_W-1)-1), 2^(SAMPLE_W-1)-1] instead of the average. Louder output, clips.
- Undefined: average mixing as above.
- Both builds keep identical latency and ports.

Decomposition:
- Package synth_pkg holds: wave-mode enum (WAVE_SINE=0, WAVE_SQUARE=1, WAVE_SAW=2, WAVE_TRI=3), FSM state typedef, default width constants.
- Sub-module wave_shaper is combinational. Inputs: phase, mode. Output: signed sample. It instantiates tableSinewave.
- tableFrequencyStep is instantiated once and addressed by index[v] during SWEEP.

Test Plan:
- Reset, then tick with no notes -> outSampleValid at T+VOICES+1 and outSample=0; outNoteReady=1 in IDLE.
- Note-on voice 0, index 69, square, then 2 ticks (VOICES=4, 12-bit) -> samples 0x7FF>>>2 = 0x1FF; phase[0] = 2·step(69).
- Voices 0 and 1 both square and in phase, voices 2 and 3 off -> 0x3FF. With POLY_SAT_MIX_EN: 0x7FF (saturated).
- Note-off voice 0 between ticks -> voice contributes 0 and its phase stays frozen; a later note-on restarts its phase at 0.
- Tick during SWEEP -> ignored, outOverrun=1 and stays set, only one outSampleValid pulse; inNoteValid during SWEEP -> outNoteReady=0, no state change.
- Assert inRST at SWEEP cycle 2 -> no outSampleValid, all outputs 0, FSM back in IDLE the next cycle.
